// File: rtl/seq_divider_pkg.sv
// div_pkg: shared state encoding, default width and sizing helper for the divider slice
package div_pkg;
    localparam int W_DEF = 16;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    function automatic int clog2(input int n);
        int r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: operand and result handshakes of the sequential divider
interface seq_divider_if import div_pkg::*; #(
    parameter int W = W_DEF
) ();
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] quotient;
    logic [W-1:0]   remainder;
    logic           overflow;
    logic           div_by_zero;
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, overflow, div_by_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, overflow, div_by_zero
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring iteration, shifts in the next dividend bit and trial-subtracts the divisor
module div_step #(
    parameter int W = 16
) (
    input  logic [W:0]   r,
    input  logic         q_msb,
    input  logic [W-1:0] divisor,
    output logic [W:0]   r_next,
    output logic         q_bit
);
    logic [W+1:0] rs;
    assign rs     = {r, q_msb};
    assign q_bit  = rs >= {2'b00, divisor};
    // the partial remainder stays below the divisor, so the top bit is always zero
    assign r_next = (W+1)'(q_bit ? rs - {2'b00, divisor} : rs);
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, 2W/W bits, one quotient bit per clock
module seq_divider import div_pkg::*; #(
    parameter int W = W_DEF
) (
    input logic          clk,
    input logic          rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = clog2(2 * W);
    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [W:0]     r, r_nx;
    logic [2*W-1:0] q, quo;
    logic [W-1:0]   d, rem;
    logic           q_bit, ovf, ovf_q, dbz_q, accept, zero;

    assign accept = state == IDLE && bus.in_valid;
    assign zero   = bus.divisor == '0;

    div_step #(.W(W)) u_step (
        .r      (r),
        .q_msb  (q[2*W-1]),
        .divisor(d),
        .r_next (r_nx),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == DONE;
        if (accept)                              state_nx = zero ? DONE : CALC;
        else if (state == CALC && cnt == '0)     state_nx = DONE;
        else if (state == DONE && bus.out_ready) state_nx = IDLE;
    end

    // results are registered only when DONE is entered, so they hold through backpressure and IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            r     <= '0;
            q     <= '0;
            d     <= '0;
            ovf   <= 1'b0;
            quo   <= '0;
            rem   <= '0;
            ovf_q <= 1'b0;
            dbz_q <= 1'b0;
        end else if (accept) begin
            cnt <= CW'(2 * W - 1);
            r   <= '0;
            q   <= bus.dividend;
            d   <= bus.divisor;
            ovf <= !zero && bus.dividend[2*W-1:W] >= bus.divisor;
            if (zero) begin
                quo   <= '1;
                rem   <= bus.dividend[W-1:0];
                ovf_q <= 1'b0;
                dbz_q <= 1'b1;
            end
        end else if (state == CALC) begin
            cnt <= cnt - 1'b1;
            r   <= r_nx;
            q   <= {q[2*W-2:0], q_bit};
            if (cnt == '0) begin
                quo   <= {q[2*W-2:0], q_bit};
                rem   <= r_nx[W-1:0];
                ovf_q <= ovf;
                dbz_q <= 1'b0;
            end
        end
    end

    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and round-trip checks of seq_divider against an arithmetic reference model
module tb_seq_divider;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vec = 0;
    int mis = 0;
    int cyc = 0;

    seq_divider_if #(.W(W)) bus ();
    seq_divider #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] quo;
        logic [15:0] rem;
        logic        ovf;
        logic        dbz;
        int          due;
    } exp_t;
    exp_t model_q[$];
    logic prev_ov = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: division by plain arithmetic, one entry per accepted operation
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] n, dv;
        if (!rst_n) begin
            model_q.delete();
            prev_ov = 1'b0;
        end else begin
            check("in_ready_vs_model", bus.in_ready, model_q.size() == 0);
            if (bus.out_valid) begin
                if (model_q.size() == 0) check("out_valid_without_op", bus.out_valid, 0);
                else begin
                    e = model_q[0];
                    if (!prev_ov) check("latency", cyc, e.due);
                    check("quotient", bus.quotient, e.quo);
                    check("remainder", bus.remainder, e.rem);
                    check("overflow", bus.overflow, e.ovf);
                    check("div_by_zero", bus.div_by_zero, e.dbz);
                    if (bus.out_ready) void'(model_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                n  = bus.dividend;
                dv = {16'h0, bus.divisor};
                if (dv == 0) begin
                    e.quo = 32'hFFFF_FFFF;
                    e.rem = n[15:0];
                    e.ovf = 1'b0;
                    e.dbz = 1'b1;
                    e.due = cyc + 1;
                end else begin
                    e.quo = n / dv;
                    e.rem = 16'(n % dv);
                    e.ovf = (n >> 16) >= dv;
                    e.dbz = 1'b0;
                    e.due = cyc + 33;
                end
                model_q.push_back(e);
            end
            prev_ov = bus.out_valid;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [15:0] b, output int t);
        bit got = 0;
        t = -1;
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready && rst_n) begin
                got = 1;
                t = cyc;
            end
        end
        if (!got) check("accept_timeout", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int c);
        bit got = 0;
        c = -1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                got = 1;
                c = cyc;
            end
        end
        if (!got) check("out_valid_timeout", bus.out_valid, 1);
    endtask

    task automatic directed(input string nm, input logic [31:0] a, input logic [15:0] b, input int lat,
                            input logic [31:0] eq, input logic [15:0] er, input logic eo, input logic ez);
        int t, c;
        issue(a, b, t);
        wait_out(c);
        check({nm, "_lat"}, c - t, lat);
        check({nm, "_quo"}, bus.quotient, eq);
        check({nm, "_rem"}, bus.remainder, er);
        check({nm, "_ovf"}, bus.overflow, eo);
        check({nm, "_dbz"}, bus.div_by_zero, ez);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish (vectors %0d)", vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, c;
        logic [31:0] a, b;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        directed("small", 32'h0000_0064, 16'h0007, 33, 32'h0000_000E, 16'h0002, 1'b0, 1'b0);
        directed("maxprod", 32'hFFFE_0001, 16'hFFFF, 33, 32'h0000_FFFF, 16'h0000, 1'b0, 1'b0);
        directed("ovf", 32'hFFFF_FFFF, 16'h0001, 33, 32'hFFFF_FFFF, 16'h0000, 1'b1, 1'b0);
        directed("dbz", 32'h1234_5678, 16'h0000, 1, 32'hFFFF_FFFF, 16'h5678, 1'b0, 1'b1);
        directed("ovf_edge", 32'h0005_0000, 16'h0005, 33, 32'h0001_0000, 16'h0000, 1'b1, 1'b0);

        // backpressure: 1000/3 held while the consumer stalls, busy in_valid ignored
        bus.out_ready = 1'b0;
        issue(32'd1000, 16'd3, t);
        wait_out(c);
        check("bp_lat", c - t, 33);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                bus.in_valid = 1'b1;
                bus.dividend = 32'd99;
                bus.divisor  = 16'd0;
            end
            if (k == 2) bus.in_valid = 1'b0;
            @(negedge clk);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_quotient", bus.quotient, 32'h0000_014D);
            check("bp_remainder", bus.remainder, 16'h0001);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_in_ready", bus.in_ready, 0);
        @(negedge clk);
        check("bp_after_in_ready", bus.in_ready, 1);
        check("bp_after_out_valid", bus.out_valid, 0);

        // reset in the middle of a calculation
        @(posedge clk);
        #1;
        issue(32'h1234_5678, 16'h1234, t);
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_quotient", bus.quotient, 0);
        check("arst_remainder", bus.remainder, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("post_rst_out_valid", bus.out_valid, 0);
        end
        check("post_rst_in_ready", bus.in_ready, 1);

        // round trip: (a*b)/b back to back, results checked by the model at T+33
        @(posedge clk);
        #1;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom_range(1, 65535);
            b = $urandom_range(1, 65535);
            issue(a * b, b[15:0], t);
        end
        wait_out(c);
        check("rt_last_quo", bus.quotient, a);
        check("rt_last_rem", bus.remainder, 0);
        check("rt_last_ovf", bus.overflow, 0);
        repeat (3) @(negedge clk);
        check("drain", model_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
